// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: two-requester round-robin write arbiter in front of a
// register-file write port. WE/AW/D are registered one cycle after the grant.
// Optional build macro RF_CLEAR_EN adds a post-reset clear sequence that
// writes zero to every entry before arbitration starts.
module rf_wr_arbiter #(
  parameter int WORDSIZE  = 32,
  parameter int BLOCKSIZE = 32,
  parameter int ADDRSIZE  = $clog2(BLOCKSIZE)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req0,
  input  logic [ADDRSIZE-1:0] i_addr0,
  input  logic [WORDSIZE-1:0] i_data0,
  output logic                o_gnt0,
  input  logic                i_req1,
  input  logic [ADDRSIZE-1:0] i_addr1,
  input  logic [WORDSIZE-1:0] i_data1,
  output logic                o_gnt1,
  output logic                o_we,
  output logic [ADDRSIZE-1:0] o_aw,
  output logic [WORDSIZE-1:0] o_d,
  output logic                o_busy
);

  logic                r_ptr;       // 0: requester 0 wins a tie, 1: requester 1
  logic                w_arb;       // grants may be issued this cycle
  logic                w_clear_wr;  // clear sequence writes this cycle
  logic [ADDRSIZE-1:0] w_clr_addr;  // address of the clear write
  logic                w_gnt0;
  logic                w_gnt1;
  logic                r_we;
  logic [ADDRSIZE-1:0] r_aw;
  logic [WORDSIZE-1:0] r_d;

`ifdef RF_CLEAR_EN
  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_t;

  // The counter is one bit wider than the address so it can rest at
  // BLOCKSIZE once every entry is written instead of wrapping to 0. The
  // extra CLEAR cycle at that value keeps BUSY high while the final clear
  // write is on the port, so BUSY falls together with WE.
  localparam logic [ADDRSIZE:0] CLR_END = (ADDRSIZE+1)'(BLOCKSIZE);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDRSIZE:0] r_clr_cnt;
  logic              w_clr_done;

  assign w_clr_done = (r_clr_cnt == CLR_END);
  assign w_clr_addr = r_clr_cnt[ADDRSIZE-1:0];
  assign o_busy     = (r_state == CLEAR);

  // State register; reset always restarts the clear sequence.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= CLEAR;
    else          r_state <= w_state_nxt;
  end

  // Next-state and per-state controls.
  always_comb begin
    w_state_nxt = r_state;
    w_arb       = 1'b0;
    w_clear_wr  = 1'b0;
    case (r_state)
      CLEAR: begin
        if (w_clr_done) w_state_nxt = ARB;
        else            w_clear_wr  = 1'b1;
      end
      ARB:     w_arb = 1'b1;
      default: w_state_nxt = CLEAR;
    endcase
  end

  // Clear address counter, saturating at BLOCKSIZE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_clr_cnt <= '0;
    else if (w_clear_wr) r_clr_cnt <= r_clr_cnt + 1'b1;
  end
`else
  // Without the clear sequence the block arbitrates from the first cycle.
  assign w_arb      = 1'b1;
  assign w_clear_wr = 1'b0;
  assign w_clr_addr = '0;
  assign o_busy     = 1'b0;
`endif

  // Round-robin grant: a lone requester always wins, a tie goes to r_ptr.
  // Gated by reset so no grant is visible while the block is held in reset.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case leaves it unassigned and a latch is never built.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (i_rst_n && w_arb) begin
      if (i_req0 && (!i_req1 || !r_ptr)) w_gnt0 = 1'b1;
      else if (i_req1)                   w_gnt1 = 1'b1;
    end
  end

  assign o_gnt0 = w_gnt0;
  assign o_gnt1 = w_gnt1;

  // Priority pointer: after a grant the other requester gets the next tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_ptr <= 1'b0;
    else if (w_gnt0) r_ptr <= 1'b1;
    else if (w_gnt1) r_ptr <= 1'b0;
  end

  // Registered write port; AW and D hold their value in idle cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we <= 1'b0;
      r_aw <= '0;
      r_d  <= '0;
    end else begin
      r_we <= w_clear_wr | w_gnt0 | w_gnt1;
      if (w_clear_wr) begin
        r_aw <= w_clr_addr;
        r_d  <= '0;
      end else if (w_gnt0) begin
        r_aw <= i_addr0;
        r_d  <= i_data0;
      end else if (w_gnt1) begin
        r_aw <= i_addr1;
        r_d  <= i_data1;
      end
    end
  end

  assign o_we = r_we;
  assign o_aw = r_aw;
  assign o_d  = r_d;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter (default parameters). Runs the
// clear-sequence scenarios when RF_CLEAR_EN is defined for the build.
module tb_rf_wr_arbiter;

  localparam int W  = 32;
  localparam int B  = 32;
  localparam int AS = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AS-1:0] addr0 = '0, addr1 = '0;
  logic [W-1:0]  data0 = '0, data1 = '0;
  logic          gnt0, gnt1, we, busy;
  logic [AS-1:0] aw;
  logic [W-1:0]  d;

  int checks = 0;
  int errors = 0;

  rf_wr_arbiter #(.WORDSIZE(W), .BLOCKSIZE(B), .ADDRSIZE(AS)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_addr0(addr0), .i_data0(data0), .o_gnt0(gnt0),
    .i_req1(req1), .i_addr1(addr1), .i_data1(data1), .o_gnt1(gnt1),
    .o_we(we), .o_aw(aw), .o_d(d), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wait (bounded) until the block is out of its clear sequence.
  task automatic wait_ready();
    int n = 0;
    while (busy !== 1'b0 && n < B + 10) begin
      @(negedge clk);
      n++;
    end
    check("ready_busy", 64'(busy), 64'd0);
  endtask

  // One table row: inputs for a cycle, expected grants that cycle and
  // expected write port in the following cycle.
  typedef struct {
    logic          r0;
    logic [AS-1:0] a0;
    logic [W-1:0]  d0;
    logic          r1;
    logic [AS-1:0] a1;
    logic [W-1:0]  d1;
    logic          g0;
    logic          g1;
    logic          we;
    logic [AS-1:0] aw;
    logic [W-1:0]  d;
  } vec_t;

  vec_t vecs[14];

  // Random-phase reference model state.
  logic          pend[2];
  logic [AS-1:0] paddr[2];
  logic [W-1:0]  pdata[2];
  logic [W-1:0]  model_rf[B];
  logic [W-1:0]  dut_rf[B];
  int            turn;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pointer starts at 0; rows chain the pointer forward.
    vecs[0]  = '{1'b1, 5'd1, 32'hAAAA0001, 1'b1, 5'd2, 32'hBBBB0002, 1'b1, 1'b0, 1'b1, 5'd1, 32'hAAAA0001};
    vecs[1]  = '{1'b1, 5'd1, 32'hAAAA0001, 1'b1, 5'd2, 32'hBBBB0002, 1'b0, 1'b1, 1'b1, 5'd2, 32'hBBBB0002};
    vecs[2]  = '{1'b1, 5'd1, 32'hAAAA0001, 1'b1, 5'd2, 32'hBBBB0002, 1'b1, 1'b0, 1'b1, 5'd1, 32'hAAAA0001};
    vecs[3]  = '{1'b1, 5'd1, 32'hAAAA0001, 1'b1, 5'd2, 32'hBBBB0002, 1'b0, 1'b1, 1'b1, 5'd2, 32'hBBBB0002};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd2, 32'hBBBB0002};
    vecs[5]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd3, 32'h22,       1'b1, 1'b0, 1'b1, 5'd3, 32'h11};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h22,       1'b0, 1'b1, 1'b1, 5'd3, 32'h22};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd3, 32'h22};
    vecs[8]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h33,       1'b0, 1'b1, 1'b1, 5'd9, 32'h33};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd10, 32'h44,      1'b0, 1'b1, 1'b1, 5'd10, 32'h44};
    vecs[11] = '{1'b1, 5'd4, 32'h55,       1'b1, 5'd6, 32'h66,       1'b1, 1'b0, 1'b1, 5'd4, 32'h55};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd4, 32'h55};
    vecs[13] = '{1'b1, 5'd7, 32'h77,       1'b1, 5'd8, 32'h88,       1'b0, 1'b1, 1'b1, 5'd8, 32'h88};

    // Reset values, with both requests raised to prove grants stay low.
    #1 rst_n = 1'b0;
    req0 = 1'b1; addr0 = 5'd9; data0 = 32'h1234;
    req1 = 1'b1; addr1 = 5'd8; data1 = 32'h5678;
    repeat (2) @(negedge clk);
    check("rst_we", 64'(we), 64'd0);
    check("rst_aw", 64'(aw), 64'd0);
    check("rst_d", 64'(d), 64'd0);
    check("rst_gnt0", 64'(gnt0), 64'd0);
    check("rst_gnt1", 64'(gnt1), 64'd0);
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;

`ifdef RF_CLEAR_EN
    // Reset mid-clear: pulse reset while address 12 is being written.
    repeat (13) @(negedge clk);
    check("mid_clr_aw", 64'(aw), 64'd12);
    #2 rst_n = 1'b0;
    #1 check("mid_clr_rst_we", 64'(we), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Full clear from address 0; requester 1 raises a request at cycle 10.
    for (int i = 0; i < B; i++) begin
      @(negedge clk);
      check($sformatf("clr_we_%0d", i), 64'(we), 64'd1);
      check($sformatf("clr_aw_%0d", i), 64'(aw), 64'(i));
      check($sformatf("clr_d_%0d", i), 64'(d), 64'd0);
      check($sformatf("clr_busy_%0d", i), 64'(busy), 64'd1);
      if (i == 10) begin
        req1 = 1'b1; addr1 = 5'd7; data1 = 32'h77777777;
      end
      #1 check($sformatf("clr_gnt1_%0d", i), 64'(gnt1), 64'd0);
    end
    @(negedge clk);
    check("clr_end_busy", 64'(busy), 64'd0);
    check("clr_end_we", 64'(we), 64'd0);
    #1 check("held_req_gnt1", 64'(gnt1), 64'd1);
    @(negedge clk);
    req1 = 1'b0;
    check("held_req_we", 64'(we), 64'd1);
    check("held_req_aw", 64'(aw), 64'd7);
    check("held_req_d", 64'(d), 64'h77777777);
`else
    @(negedge clk);
    check("no_clear_busy", 64'(busy), 64'd0);
`endif

    // Directed arbitration table.
    for (int i = 0; i < 14; i++) begin
      req0 = vecs[i].r0; addr0 = vecs[i].a0; data0 = vecs[i].d0;
      req1 = vecs[i].r1; addr1 = vecs[i].a1; data1 = vecs[i].d1;
      #1;
      check($sformatf("vec%0d_gnt0", i), 64'(gnt0), 64'(vecs[i].g0));
      check($sformatf("vec%0d_gnt1", i), 64'(gnt1), 64'(vecs[i].g1));
      @(negedge clk);
      check($sformatf("vec%0d_we", i), 64'(we), 64'(vecs[i].we));
      check($sformatf("vec%0d_aw", i), 64'(aw), 64'(vecs[i].aw));
      check($sformatf("vec%0d_d", i), 64'(d), 64'(vecs[i].d));
    end

    // Reset mid-transfer: the write on the port is dropped at once.
    req0 = 1'b1; addr0 = 5'd5; data0 = 32'h12345678; req1 = 1'b0;
    #1 check("xfer_gnt0", 64'(gnt0), 64'd1);
    @(posedge clk);
    #1 check("xfer_we", 64'(we), 64'd1);
    rst_n = 1'b0;
    #1;
    check("xfer_rst_we", 64'(we), 64'd0);
    check("xfer_rst_aw", 64'(aw), 64'd0);
    check("xfer_rst_d", 64'(d), 64'd0);
    check("xfer_rst_gnt0", 64'(gnt0), 64'd0);
    req0 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    wait_ready();

    // Randomized traffic against a transaction-level model: each requester
    // holds its request until granted; ties alternate; each grant is one
    // write on the port in the next cycle; final contents compared.
    for (int k = 0; k < 2; k++) pend[k] = 1'b0;
    for (int a = 0; a < B; a++) begin
      model_rf[a] = '0;
      dut_rf[a]   = '0;
    end
    turn = 0;
    begin
      logic          have_exp;
      logic          exp_we;
      logic [AS-1:0] exp_aw;
      logic [W-1:0]  exp_d;
      int            g;
      have_exp = 1'b0;
      exp_we = 1'b0; exp_aw = '0; exp_d = '0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (have_exp) begin
          check("rnd_we", 64'(we), 64'(exp_we));
          check("rnd_aw", 64'(aw), 64'(exp_aw));
          check("rnd_d", 64'(d), 64'(exp_d));
        end
        if (we === 1'b1) dut_rf[aw] = d;
        for (int k = 0; k < 2; k++) begin
          if (!pend[k] && $urandom_range(0, 99) < 60) begin
            pend[k]  = 1'b1;
            paddr[k] = AS'($urandom_range(0, 7));
            pdata[k] = $urandom;
          end
        end
        req0 = pend[0]; addr0 = paddr[0]; data0 = pdata[0];
        req1 = pend[1]; addr1 = paddr[1]; data1 = pdata[1];
        #1;
        if (pend[0] && pend[1]) g = turn;
        else if (pend[0])       g = 0;
        else if (pend[1])       g = 1;
        else                    g = -1;
        check("rnd_gnt0", 64'(gnt0), 64'(g == 0));
        check("rnd_gnt1", 64'(gnt1), 64'(g == 1));
        if (g >= 0) begin
          exp_we = 1'b1;
          exp_aw = paddr[g];
          exp_d  = pdata[g];
          model_rf[paddr[g]] = pdata[g];
          pend[g] = 1'b0;
          turn = 1 - g;
        end else begin
          exp_we = 1'b0;
        end
        have_exp = 1'b1;
      end
      @(negedge clk);
      check("rnd_last_we", 64'(we), 64'(exp_we));
      if (we === 1'b1) dut_rf[aw] = d;
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int a = 0; a < 8; a++)
      check($sformatf("rf_entry_%0d", a), 64'(dut_rf[a]), 64'(model_rf[a]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameter WORDSIZE, default 32: data word width.
REQ-002 Parameter BLOCKSIZE, default 32: number of register-file entries.
REQ-003 Parameter ADDRSIZE, default $clog2(BLOCKSIZE): address width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 CLK  in  1: clock; all state SHALL update on its rising edge.
REQ-006 RST_N  in  1: asynchronous active-low reset.
REQ-007 REQ0  in  1: requester 0 write request.
REQ-008 ADDR0  in  ADDRSIZE: requester 0 target address.
REQ-009 DATA0  in  WORDSIZE: requester 0 write data.
REQ-010 GNT0  out  1: requester 0 accepted this cycle (combinational).
REQ-011 REQ1, ADDR1, DATA1 (in) and GNT1 (out): as REQ-007 to REQ-010, for requester 1.
REQ-012 WE  out  1: register-file write enable (registered).
REQ-013 AW  out  ADDRSIZE: register-file write address (registered).
REQ-014 D  out  WORDSIZE: register-file write data (registered).
REQ-015 BUSY  out  1: clear sequence in progress; no grants are issued while high.

Function
REQ-016 The FSM SHALL have two states: CLEAR and ARB.
REQ-017 In ARB, a request is accepted in cycle N when GNTk=1. WE, AW and D SHALL then show that request in cycle N+1.
- Accept-to-register-file-write latency: 1 cycle.
- Requesters hold REQk, ADDRk and DATAk stable until GNTk is seen.
REQ-018 At most one GNT SHALL be high per cycle, and a GNT is never high without its REQ.
REQ-019 Arbitration SHALL be round-robin between the two requesters.
- Only one REQ high: that requester is granted.
- Both REQ high: the requester selected by the priority pointer is granted.
- After any grant to k, the pointer moves to the other requester.
- The pointer is unchanged in cycles with no grant.
REQ-020 Any cycle in ARB with no grant SHALL produce WE=0 in the next cycle. AW and D hold their last values.
REQ-021 Both requesters targeting the same address SHALL be serialized in grant order, so the later-granted data is the final content.
REQ-022 In CLEAR, the block SHALL write 0 to every address from 0 up to BLOCKSIZE-1, one address per cycle.
- WE=1, D=0, AW=clear counter, BUSY=1, GNT0=GNT1=0 throughout.
REQ-023 After the write to BLOCKSIZE-1, the FSM SHALL move to ARB and BUSY SHALL fall in the same cycle WE for that final write is low.
- The clear counter does not wrap.
- Total clear duration: BLOCKSIZE cycles of WE=1.
REQ-024 Requests raised during CLEAR SHALL be held off (no grant) and SHALL NOT be lost. They are served in ARB once the requester still holds REQ.

Reset
REQ-025 While RST_N=0, the outputs SHALL take these values:
- WE=0, AW=0, D=0, GNT0=GNT1=0.
- Priority pointer = requester 0.
- Clear counter = 0.
REQ-026 On reset release, the FSM SHALL enter CLEAR when RF_CLEAR_EN is defined, and ARB otherwise.
REQ-027 Reset asserted mid-clear or mid-transfer SHALL abort the operation immediately.
- The in-flight write is dropped (WE=0).
- A clear restarts from address 0.

Configuration
REQ-028 Macro RF_CLEAR_EN SHALL control the clear sequence.
- Defined: CLEAR state and clear counter are present; behaviour per REQ-022 to REQ-024.
- Undefined: no CLEAR state or counter; BUSY is tied to 0; arbitration starts in the first cycle after reset.

Verification
REQ-029 Clear after reset (RF_CLEAR_EN defined, BLOCKSIZE=32): release RST_N -> 32 consecutive cycles of WE=1, D=0, AW=0..31, then BUSY=0 and WE=0.
REQ-030 Single requester: REQ0=1, ADDR0=5, DATA0=0xDEADBEEF in cycle N -> GNT0=1 in cycle N; WE=1, AW=5, D=0xDEADBEEF in cycle N+1.
REQ-031 Contention: REQ0 and REQ1 held high for 4 cycles, pointer at 0 -> grant sequence GNT0, GNT1, GNT0, GNT1.
- WE stays high on 4 back-to-back cycles.
REQ-032 Same address: both requesters target address 3, DATA0=0x11, DATA1=0x22, pointer at 0 -> writes 0x11 then 0x22 on consecutive cycles.
REQ-033 Request during clear: REQ1=1 with ADDR1=7 asserted at clear cycle 10 -> no GNT1 until BUSY=0, then GNT1=1.
- The write to address 7 appears after the write to address 31.
REQ-034 Reset mid-clear: RST_N pulsed low at clear address 12 -> WE=0 immediately; the clear restarts at AW=0 after release.
